// File: rtl/id_ex_reg_if.sv
// id_ex_reg_if: decode-stage fields, hazard controls and registered EX-stage fields of the ID/EX register
interface id_ex_reg_if;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_alu_op;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_mem_to_reg;
  logic        id_alu_src;
  logic        id_is_clo;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_alu_op;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_alu_src;
  logic        ex_is_clo;
  logic [31:0] ex_clz_operand;
  logic [4:0]  ex_load_use_rt;
  modport master (
    output stall, flush, id_valid, id_pc, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_alu_op, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_is_clo,
    input  ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_alu_op,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_is_clo,
           ex_clz_operand, ex_load_use_rt
  );
  modport slave (
    input  stall, flush, id_valid, id_pc, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_alu_op, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_is_clo,
    output ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_alu_op,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_is_clo,
           ex_clz_operand, ex_load_use_rt
  );
endinterface

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with stall/flush; IDEX_CLO_EN inverts the counter operand for CLO
module id_ex_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic      clk,
  input logic      rst,
  id_ex_reg_if.slave b
);
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] clz_operand;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        is_clo;
  } stage_t;
  // valid and pc lead the struct so the bubble is just RESET_PC over zeros
  localparam stage_t BUBBLE = stage_t'({1'b0, RESET_PC, {($bits(stage_t) - 33){1'b0}}});
  stage_t q, load;
  always_comb begin
    load = '0;
    load.valid = 1'b1;
    load.pc = b.id_pc;
    load.rs_data = b.id_rs_data;
    load.rt_data = b.id_rt_data;
    load.imm = b.id_imm;
    load.rs = b.id_rs;
    load.rt = b.id_rt;
    load.rd = b.id_rd;
    load.alu_op = b.id_alu_op;
    load.reg_write = b.id_reg_write;
    load.mem_read = b.id_mem_read;
    load.mem_write = b.id_mem_write;
    load.mem_to_reg = b.id_mem_to_reg;
    load.alu_src = b.id_alu_src;
`ifdef IDEX_CLO_EN
    load.clz_operand = b.id_is_clo ? ~b.id_rs_data : b.id_rs_data;
    load.is_clo = b.id_is_clo;
`else
    load.clz_operand = b.id_rs_data;
    load.is_clo = b.id_is_clo & 1'b0;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= BUBBLE;
    else if (b.flush) q <= BUBBLE;
    else if (!b.stall) q <= b.id_valid ? load : BUBBLE;
  assign b.ex_valid = q.valid;
  assign b.ex_pc = q.pc;
  assign b.ex_rs_data = q.rs_data;
  assign b.ex_rt_data = q.rt_data;
  assign b.ex_imm = q.imm;
  assign b.ex_rs = q.rs;
  assign b.ex_rt = q.rt;
  assign b.ex_rd = q.rd;
  assign b.ex_alu_op = q.alu_op;
  assign b.ex_reg_write = q.reg_write;
  assign b.ex_mem_read = q.mem_read;
  assign b.ex_mem_write = q.mem_write;
  assign b.ex_mem_to_reg = q.mem_to_reg;
  assign b.ex_alu_src = q.alu_src;
  assign b.ex_is_clo = q.is_clo;
  assign b.ex_clz_operand = q.clz_operand;
  assign b.ex_load_use_rt = q.mem_read ? q.rt : 5'd0;
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: scoreboard bench for id_ex_reg (directed plan plus random stall/flush traffic)
module tb_id_ex_reg;
  localparam logic [31:0] RPC = 32'hBFC0_0000;
  typedef struct {
    logic        valid;
    logic [31:0] pc, rs_data, rt_data, imm, clz;
    logic [4:0]  rs, rt, rd, alu_op, lu;
    logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, is_clo;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t m;
  exp_t sb[$];
  id_ex_reg_if bus();
  id_ex_reg #(.RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .b(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic exp_t bub();
    exp_t r;
    r = '{valid: 1'b0, pc: RPC, rs_data: '0, rt_data: '0, imm: '0, clz: '0, rs: '0, rt: '0, rd: '0,
          alu_op: '0, lu: '0, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
          alu_src: 1'b0, is_clo: 1'b0};
    return r;
  endfunction
  function automatic int clz(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return 31 - i;
    return 32;
  endfunction
  function automatic exp_t nxt(input exp_t cur);
    exp_t r;
    if (bus.flush) return bub();
    if (bus.stall) return cur;
    if (!bus.id_valid) return bub();
    r.valid = 1'b1;
    r.pc = bus.id_pc;
    r.rs_data = bus.id_rs_data;
    r.rt_data = bus.id_rt_data;
    r.imm = bus.id_imm;
    r.rs = bus.id_rs;
    r.rt = bus.id_rt;
    r.rd = bus.id_rd;
    r.alu_op = bus.id_alu_op;
    r.reg_write = bus.id_reg_write;
    r.mem_read = bus.id_mem_read;
    r.mem_write = bus.id_mem_write;
    r.mem_to_reg = bus.id_mem_to_reg;
    r.alu_src = bus.id_alu_src;
`ifdef IDEX_CLO_EN
    r.is_clo = bus.id_is_clo;
    r.clz = bus.id_is_clo ? ~bus.id_rs_data : bus.id_rs_data;
`else
    r.is_clo = 1'b0;
    r.clz = bus.id_rs_data;
`endif
    r.lu = r.mem_read ? r.rt : 5'd0;
    return r;
  endfunction
  task automatic compare(input exp_t e);
    chk("valid", bus.ex_valid, e.valid);
    chk("pc", bus.ex_pc, e.pc);
    chk("rs_data", bus.ex_rs_data, e.rs_data);
    chk("rt_data", bus.ex_rt_data, e.rt_data);
    chk("imm", bus.ex_imm, e.imm);
    chk("rs", bus.ex_rs, e.rs);
    chk("rt", bus.ex_rt, e.rt);
    chk("rd", bus.ex_rd, e.rd);
    chk("alu_op", bus.ex_alu_op, e.alu_op);
    chk("reg_write", bus.ex_reg_write, e.reg_write);
    chk("mem_read", bus.ex_mem_read, e.mem_read);
    chk("mem_write", bus.ex_mem_write, e.mem_write);
    chk("mem_to_reg", bus.ex_mem_to_reg, e.mem_to_reg);
    chk("alu_src", bus.ex_alu_src, e.alu_src);
    chk("is_clo", bus.ex_is_clo, e.is_clo);
    chk("clz_operand", bus.ex_clz_operand, e.clz);
    chk("load_use_rt", bus.ex_load_use_rt, e.lu);
  endtask
  task automatic rnd();
    bus.id_valid = 1'($urandom_range(0, 3) != 0);
    bus.id_pc = $urandom;
    bus.id_rs_data = $urandom;
    bus.id_rt_data = $urandom;
    bus.id_imm = $urandom;
    bus.id_rs = 5'($urandom);
    bus.id_rt = 5'($urandom);
    bus.id_rd = 5'($urandom);
    bus.id_alu_op = 5'($urandom);
    bus.id_reg_write = 1'($urandom);
    bus.id_mem_read = 1'($urandom);
    bus.id_mem_write = 1'($urandom);
    bus.id_mem_to_reg = 1'($urandom);
    bus.id_alu_src = 1'($urandom);
    bus.id_is_clo = 1'($urandom);
  endtask
  task automatic step(input logic st, input logic fl);
    exp_t e;
    bus.stall = st;
    bus.flush = fl;
    m = nxt(m);
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compare(e);
  endtask
  initial begin
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    rnd();
    m = bub();
    @(negedge clk);
    compare(bub());
    rst = 1'b0;
    rnd();
    bus.id_valid = 1'b1;
    bus.id_pc = 32'h0000_0040;
    bus.id_rs_data = 32'h0000_FFFF;
    bus.id_rd = 5'd9;
    bus.id_reg_write = 1'b1;
    bus.id_is_clo = 1'b0;
    step(1'b0, 1'b0);
    chk("load_pc", bus.ex_pc, 32'h40);
    chk("load_clz", bus.ex_clz_operand, 32'h0000_FFFF);
    chk("load_rd", bus.ex_rd, 32'd9);
    chk("load_valid", bus.ex_valid, 32'd1);
    for (int i = 0; i < 3; i++) begin
      rnd();
      step(1'b1, 1'b0);
      chk("stall_pc", bus.ex_pc, 32'h40);
    end
    bus.id_valid = 1'b1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("flush_valid", bus.ex_valid, 32'd0);
    chk("flush_pc", bus.ex_pc, RPC);
    rnd();
    bus.id_valid = 1'b1;
    bus.id_mem_read = 1'b1;
    bus.id_rt = 5'd4;
    step(1'b0, 1'b0);
    chk("load_use", bus.ex_load_use_rt, 32'd4);
    bus.id_valid = 1'b0;
    step(1'b0, 1'b0);
    chk("load_use_bubble", bus.ex_load_use_rt, 32'd0);
    rnd();
    bus.id_valid = 1'b1;
    bus.id_is_clo = 1'b1;
    bus.id_rs_data = 32'hF000_0000;
    step(1'b0, 1'b0);
`ifdef IDEX_CLO_EN
    chk("clo_operand", bus.ex_clz_operand, 32'h0FFF_FFFF);
    chk("clo_count", clz(bus.ex_clz_operand), 32'd4);
    chk("clo_flag", bus.ex_is_clo, 32'd1);
`else
    chk("clo_operand", bus.ex_clz_operand, 32'hF000_0000);
    chk("clo_flag", bus.ex_is_clo, 32'd0);
`endif
    rnd();
    bus.id_valid = 1'b1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    m = bub();
    compare(m);
    @(posedge clk);
    #1;
    compare(m);
    @(negedge clk);
    rst = 1'b0;
    bus.stall = 1'b0;
    for (int i = 0; i < 80; i++) begin
      rnd();
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register of the MIPS pipeline CPU. It captures decoded operands, register numbers and control bits from the decode stage and presents them to the EX stage, including the leading-zero counter, which takes its 32-bit input from `ex_clz_operand`. It supports hazard-driven stall (hold) and flush (bubble insertion). Optionally it pre-conditions the counter operand so the same counter also serves CLO.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: value loaded into `ex_pc` on reset and on bubble.

Ports:
- `clk` input 1: pipeline clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `stall` input 1: hold the current contents (from the hazard unit).
- `flush` input 1: load a bubble (from branch/jump resolution).
- `id_valid` input 1: the decode stage holds a real instruction.
- `id_pc` input 32: instruction PC.
- `id_rs_data` input 32: rs operand value.
- `id_rt_data` input 32: rt operand value.
- `id_imm` input 32: extended immediate.
- `id_rs` input 5: rs register number.
- `id_rt` input 5: rt register number.
- `id_rd` input 5: rd register number.
- `id_alu_op` input 5: ALU operation code.
- `id_reg_write` input 1: control bit.
- `id_mem_read` input 1: control bit.
- `id_mem_write` input 1: control bit.
- `id_mem_to_reg` input 1: control bit.
- `id_alu_src` input 1: control bit.
- `id_is_clo` input 1: instruction is CLO; used only when `IDEX_CLO_EN` is defined.
- `ex_valid` output 1, and `ex_pc`, `ex_rs_data`, `ex_rt_data`, `ex_imm`, `ex_rs`, `ex_rt`, `ex_rd`, `ex_alu_op`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_alu_src`, `ex_is_clo` outputs: registered copies of the matching `id_*` inputs, same widths.
- `ex_clz_operand` output 32: registered operand for the leading-zero counter.
- `ex_load_use_rt` output 5: equals `ex_rt` when `ex_mem_read` = 1, else 0. Combinational from registered state; consumed by the hazard unit.

## Operation
- Every register updates on the rising edge of `clk`, and only when not in reset.
- Priority per edge: `flush` > `stall` > load.
- Flush: load a bubble.
  - `ex_valid` = 0; every control bit = 0; `ex_alu_op` = 0.
  - `ex_rs`, `ex_rt`, `ex_rd` = 0.
  - All data fields = 0; `ex_pc` = `RESET_PC`.
- Stall (with `flush` = 0): every output register holds its value.
- Load (`flush` = 0, `stall` = 0):
  - If `id_valid` = 1, capture all `id_*` fields and set `ex_valid` = 1.
  - If `id_valid` = 0, load a bubble exactly as for flush.
- `ex_clz_operand` is captured on every load from `id_rs_data`, conditioned as described under Configuration. It is zeroed on a bubble. A zero operand makes the counter output 32, which is harmless because a bubble has `ex_reg_write` = 0.
- Register 0 semantics are not altered here. Register numbers pass through unchanged.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on `ex_*` after edge N.
- No combinational path from any `id_*` input to any `ex_*` output.
- Reset: asserting `rst` immediately (asynchronously) forces the bubble state, including `ex_pc` = `RESET_PC` and `ex_valid` = 0. The block resumes loading on the first edge after `rst` deasserts.
- Reset asserted mid-stall: the held instruction is discarded.
- `stall` and `flush` high together: flush wins, and a bubble is loaded on that edge.
- A stall lasting K cycles keeps the outputs constant for K edges. The first edge with `stall` = 0 loads the `id_*` values present at that edge.

## Configuration
- Macro: `IDEX_CLO_EN`.
- Defined:
  - `ex_clz_operand` = ~`id_rs_data` when `id_is_clo` = 1, else `id_rs_data`.
  - `ex_is_clo` = `id_is_clo` (registered).
  - Result: the leading-zero counter returns the leading-ones count for CLO.
- Not defined:
  - `ex_clz_operand` = `id_rs_data` always.
  - `id_is_clo` is ignored; `ex_is_clo` is tied to 0.

## Test plan
- Reset: assert `rst` between edges → all outputs change immediately; `ex_valid` = 0, `ex_pc` = 0, `ex_clz_operand` = 0.
- Load: `id_valid` = 1, `id_pc` = 32'h0000_0040, `id_rs_data` = 32'h0000_FFFF, `id_rd` = 5'd9, `id_reg_write` = 1 → after the next edge, `ex_pc` = 32'h40, `ex_clz_operand` = 32'h0000_FFFF, `ex_rd` = 9, `ex_valid` = 1.
- Stall: with the above loaded, hold `stall` = 1 for 3 edges while changing every `id_*` input → outputs unchanged. Release `stall` → the new values load on the next edge.
- Flush priority: `stall` = 1 and `flush` = 1 on the same edge → `ex_valid` = 0, `ex_reg_write` = 0, `ex_rd` = 0, `ex_pc` = `RESET_PC`.
- Load-use: load `id_mem_read` = 1, `id_rt` = 5'd4 → `ex_load_use_rt` = 4. Then load a bubble → `ex_load_use_rt` = 0.
- CLO (`IDEX_CLO_EN` defined): `id_is_clo` = 1, `id_rs_data` = 32'hF000_0000 → `ex_clz_operand` = 32'h0FFF_FFFF and the counter outputs 4. Without the macro → `ex_clz_operand` = 32'hF000_0000 and `ex_is_clo` = 0.
